ks_pg_pipe: RTL and testbench
=============================

Name: ks_pg_pipe

Overview:
- Registered pre-processing stage of the 16-bit Kogge-Stone adder. It sits directly upstream of the first prefix stage.
- Takes operands a, b and carry-in, and computes bitwise propagate (pk = a ^ b) and generate (gk = a & b).
- Presents {c0, pk, gk} from a register to the prefix network.
- Adds a valid/ready handshake with a 2-entry skid buffer, so the FFT butterfly datapath can stall the adder chain without losing operands.

Parameters:
- WIDTH, 16, operand width; must match the prefix network width.
- CNT_W, 16, width of the accepted-transaction counter.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  synchronous reset, active-high.
- i_valid  in  1  upstream operand valid.
- o_ready  out  1  stage can accept an operand this cycle.
- i_a  in  WIDTH  operand a.
- i_b  in  WIDTH  operand b.
- i_c0  in  1  carry-in.
- o_valid  out  1  {o_c0, o_pk, o_gk} valid.
- i_ready  in  1  downstream prefix stage accepts.
- o_c0  out  1  registered carry-in, goes to the prefix stage c0.
- o_pk  out  WIDTH  registered propagate, a^b.
- o_gk  out  WIDTH  registered generate, a&b.
- o_count  out  CNT_W  number of accepted operands, modulo 2^CNT_W.

Behaviour:
- Reset (i_rst=1 at an edge) clears everything:
  - o_valid=0, o_c0=0, o_pk=0, o_gk=0, o_count=0.
  - Skid entry invalidated; state=EMPTY; o_ready=1 in the following cycle.
  - Reset mid-transfer discards both entries and does not count them.
- Transfer definitions:
  - Accept = i_valid & o_ready.
  - Emit = o_valid & i_ready.
- Compute on accept: pk=i_a^i_b, gk=i_a&i_b, c0=i_c0. No arithmetic widening; bit k depends only on bit k.
- Latency: 1 cycle from accept to o_valid when the output register is free.
- o_ready is registered and equals (state != FULL). It does not combinationally depend on i_ready.
- FSM states:
  - EMPTY: output register empty.
  - ONE: output register holds data.
  - FULL: output register and skid register both hold data.
- Transitions:
  - EMPTY: accept -> ONE (load output register).
  - ONE, accept & emit -> ONE (load output register with the new data).
  - ONE, accept & !emit -> FULL (new data goes to skid).
  - ONE, !accept & emit -> EMPTY.
  - ONE, neither -> ONE.
  - FULL: emit -> ONE (skid moves to the output register); no accept is possible since o_ready=0.
- While o_valid=1 and i_ready=0, o_c0/o_pk/o_gk are held stable. No data is dropped, duplicated or reordered.
- o_count increments by 1 on every accept and wraps from 2^CNT_W-1 to 0.
- Inputs i_a/i_b/i_c0 are don't-care when i_valid=0.

Optional Feature:
- Macro: KS_PG_SUB_EN.
- Defined:
  - Adds input port i_sub (1 bit), captured with the operands.
  - When i_sub=1 the stage uses b' = ~i_b and forces c0=1, so downstream computes a-b.
  - When i_sub=0 it behaves exactly as without the macro.
- Not defined:
  - No i_sub port; always addition with c0=i_c0.

Decomposition:
- Package ks_pkg:
  - KS_WIDTH=16 constant.
  - Typedef ks_pg_t {c0, pk[WIDTH], gk[WIDTH]}, the entry type held in both registers.
  - Enum ks_pg_state_t {EMPTY, ONE, FULL}.
- Sub-module: pg_cell (per-bit p/g). It is trivial, so instantiating it is optional.
- The skid/state logic stays inline, one module.

Test Plan:
- Basic compute: a=16'h00FF, b=16'h0F0F, c0=0, i_ready=1 -> next cycle o_valid=1, o_pk=16'h0FF0, o_gk=16'h000F, o_c0=0, o_count=1.
- Backpressure:
  - Setup: i_ready=0, three consecutive valid operands X0=0x1111, X1=0x2222, X2=0x3333 (b=0).
  - Required: X0 in the output register, X1 in skid, o_ready=0 from cycle 3 onward so X2 is held upstream.
  - Release i_ready=1 -> X0, X1, X2 emitted in order, pk values 0x1111, 0x2222, 0x3333, no gaps once skid drains.
- Stable hold: o_valid=1, i_ready=0 for 10 cycles with i_a toggling -> o_pk/o_gk/o_c0 unchanged.
- Reset mid-operation: state FULL, assert i_rst one cycle -> o_valid=0, o_pk=0, o_gk=0, o_count=0, then o_ready=1; prior data never emitted.
- Counter wrap: CNT_W=4, 17 accepts -> o_count=1.
- KS_PG_SUB_EN: a=0x0005, b=0x0003, i_sub=1 -> o_pk=16'hFFF9, o_gk=16'h0004, o_c0=1; same operands with i_sub=0, c0=0 -> o_pk=16'h0006, o_gk=16'h0001, o_c0=0.

Source files
------------

// File: rtl/ks_pkg.sv
// ks_pkg: shared types for the Kogge-Stone adder pre-processing stage.
//   KS_WIDTH      - operand width of the adder (16).
//   ks_pg_t       - one propagate/generate entry {c0, pk, gk}. It is used for
//                   both the output register and the skid register.
//   ks_pg_state_t - occupancy of the output and skid registers.
package ks_pkg;

  localparam int KS_WIDTH = 16;

  typedef struct packed {
    logic                c0;
    logic [KS_WIDTH-1:0] pk;
    logic [KS_WIDTH-1:0] gk;
  } ks_pg_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,  // output register empty
    ONE   = 2'd1,  // output register holds data
    FULL  = 2'd2   // output and skid registers both hold data
  } ks_pg_state_t;

endpackage

// File: rtl/pg_cell.sv
// pg_cell: single-bit propagate/generate cell.
//   a, b : operand bits
//   p    : propagate, a ^ b
//   g    : generate,  a & b
module pg_cell (
  input  logic a,
  input  logic b,
  output logic p,
  output logic g
);

  assign p = a ^ b;
  assign g = a & b;

endmodule

// File: rtl/ks_pg_pipe.sv
// ks_pg_pipe: registered propagate/generate stage in front of the first
// Kogge-Stone prefix stage. It has a valid/ready handshake and a 2-entry
// (output + skid) buffer, so downstream can stall without losing operands.
//
// Optional feature (macro KS_PG_SUB_EN): adds input i_sub. When i_sub=1 the
// stage inverts b and forces c0=1, so the adder computes a-b.
//
// Ports:
//   i_clk, i_rst    clock, synchronous active-high reset
//   i_valid/o_ready upstream handshake (o_ready is registered)
//   i_a, i_b, i_c0  operands and carry-in
//   i_sub           subtract select (only when KS_PG_SUB_EN is defined)
//   o_valid/i_ready downstream handshake
//   o_c0,o_pk,o_gk  registered carry-in, propagate and generate
//   o_count         accepted-operand counter, wraps modulo 2^CNT_W
//
// WIDTH must equal ks_pkg::KS_WIDTH, because the entry type comes from the package.
module ks_pg_pipe
  import ks_pkg::*;
#(
  parameter int WIDTH = KS_WIDTH,
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_c0,
`ifdef KS_PG_SUB_EN
  input  logic             i_sub,
`endif
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_c0,
  output logic [WIDTH-1:0] o_pk,
  output logic [WIDTH-1:0] o_gk,
  output logic [CNT_W-1:0] o_count
);

  ks_pg_state_t     state_q, state_d;
  ks_pg_t           out_q, out_d;
  ks_pg_t           skid_q, skid_d;
  logic             ready_q, ready_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [WIDTH-1:0] b_eff;
  logic             c0_eff;
  logic [WIDTH-1:0] cell_p;
  logic [WIDTH-1:0] cell_g;
  ks_pg_t           new_pg;
  logic             accept;
  logic             emit;

  // Subtraction is a + ~b + 1, so b is inverted and the carry-in is forced to 1.
`ifdef KS_PG_SUB_EN
  assign b_eff  = i_sub ? ~i_b : i_b;
  assign c0_eff = i_sub ? 1'b1 : i_c0;
`else
  assign b_eff  = i_b;
  assign c0_eff = i_c0;
`endif

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pg
    pg_cell u_pg_cell (
      .a (i_a[gi]),
      .b (b_eff[gi]),
      .p (cell_p[gi]),
      .g (cell_g[gi])
    );
  end

  always_comb begin
    new_pg    = '0;
    new_pg.c0 = c0_eff;
    new_pg.pk = cell_p;
    new_pg.gk = cell_g;
  end

  assign accept = i_valid & ready_q;
  assign emit   = (state_q != EMPTY) & i_ready;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    count_d = count_q;

    if (accept) begin
      count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    case (state_q)
      EMPTY: begin
        if (accept) begin
          out_d   = new_pg;
          state_d = ONE;
        end
      end
      ONE: begin
        if (accept && emit) begin
          out_d = new_pg;
        end else if (accept) begin
          skid_d  = new_pg;
          state_d = FULL;
        end else if (emit) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        // ready_q is low in FULL, so no operand can arrive here.
        if (emit) begin
          out_d   = skid_q;
          state_d = ONE;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase

    // o_ready is computed from the next state, so it does not depend combinationally on i_ready.
    ready_d = (state_d != FULL);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= EMPTY;
      out_q   <= '0;
      skid_q  <= '0;
      ready_q <= 1'b1;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
      ready_q <= ready_d;
      count_q <= count_d;
    end
  end

  assign o_ready = ready_q;
  assign o_valid = (state_q != EMPTY);
  assign o_c0    = out_q.c0;
  assign o_pk    = out_q.pk;
  assign o_gk    = out_q.gk;
  assign o_count = count_q;

endmodule

// File: tb/tb_ks_pg_pipe.sv
// tb_ks_pg_pipe: directed-vector bench for ks_pg_pipe. A second instance with
// CNT_W=4 shares the same inputs so that counter wrap can be observed.
module tb_ks_pg_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        c0;
`ifdef KS_PG_SUB_EN
  logic        sub;
`endif
  logic        out_valid;
  logic        ds_ready;
  logic        out_c0;
  logic [15:0] out_pk;
  logic [15:0] out_gk;
  logic [15:0] out_count;

  logic        out_ready4;
  logic        out_valid4;
  logic        out_c04;
  logic [15:0] out_pk4;
  logic [15:0] out_gk4;
  logic [3:0]  out_count4;

  int checks   = 0;
  int failures = 0;

  ks_pg_pipe #(.WIDTH(16), .CNT_W(16)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_valid (in_valid),
    .o_ready (out_ready),
    .i_a     (a),
    .i_b     (b),
    .i_c0    (c0),
`ifdef KS_PG_SUB_EN
    .i_sub   (sub),
`endif
    .o_valid (out_valid),
    .i_ready (ds_ready),
    .o_c0    (out_c0),
    .o_pk    (out_pk),
    .o_gk    (out_gk),
    .o_count (out_count)
  );

  ks_pg_pipe #(.WIDTH(16), .CNT_W(4)) dut4 (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_valid (in_valid),
    .o_ready (out_ready4),
    .i_a     (a),
    .i_b     (b),
    .i_c0    (c0),
`ifdef KS_PG_SUB_EN
    .i_sub   (sub),
`endif
    .o_valid (out_valid4),
    .i_ready (ds_ready),
    .o_c0    (out_c04),
    .o_pk    (out_pk4),
    .o_gk    (out_gk4),
    .o_count (out_count4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Move to 1 time unit after the next rising edge. Inputs are driven and
  // outputs are sampled there, away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", out_valid); end
    checks++; if (out_pk !== 16'h0) begin failures++; $display("FAIL reset_pk got=%h exp=0000", out_pk); end
    checks++; if (out_gk !== 16'h0) begin failures++; $display("FAIL reset_gk got=%h exp=0000", out_gk); end
    checks++; if (out_c0 !== 1'b0) begin failures++; $display("FAIL reset_c0 got=%0b exp=0", out_c0); end
    checks++; if (out_count !== 16'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", out_count); end
    checks++; if (out_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%0b exp=1", out_ready); end
    $display("reset: valid=%0b ready=%0b count=%0d", out_valid, out_ready, out_count);
  endtask

  task automatic test_basic();
    ds_ready = 1'b1;
    in_valid = 1'b1; a = 16'h00FF; b = 16'h0F0F; c0 = 1'b0;
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL basic_valid got=%0b exp=1", out_valid); end
    checks++; if (out_pk !== 16'h0FF0) begin failures++; $display("FAIL basic_pk got=%h exp=0ff0", out_pk); end
    checks++; if (out_gk !== 16'h000F) begin failures++; $display("FAIL basic_gk got=%h exp=000f", out_gk); end
    checks++; if (out_c0 !== 1'b0) begin failures++; $display("FAIL basic_c0 got=%0b exp=0", out_c0); end
    checks++; if (out_count !== 16'd1) begin failures++; $display("FAIL basic_count got=%0d exp=1", out_count); end
    $display("basic: a=00ff b=0f0f pk=%h gk=%h c0=%0b", out_pk, out_gk, out_c0);
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_drain got=%0b exp=0", out_valid); end
    // c0=1 with a different pattern; the data register is held after the drain.
    in_valid = 1'b1; a = 16'hA5A5; b = 16'hFFFF; c0 = 1'b1;
    step();
    in_valid = 1'b0;
    checks++; if (out_pk !== 16'h5A5A || out_gk !== 16'hA5A5 || out_c0 !== 1'b1)
      begin failures++; $display("FAIL basic2 got=%h/%h/%0b exp=5a5a/a5a5/1", out_pk, out_gk, out_c0); end
    $display("basic2: a=a5a5 b=ffff pk=%h gk=%h c0=%0b", out_pk, out_gk, out_c0);
    step();
  endtask

  task automatic test_backpressure();
    ds_ready = 1'b0;
    b = 16'h0; c0 = 1'b0;
    in_valid = 1'b1; a = 16'h1111;
    step();  // X0 accepted into the output register
    checks++; if (out_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_one got=%0b exp=1", out_ready); end
    a = 16'h2222;
    step();  // X1 accepted into the skid register
    a = 16'h3333;
    for (int i = 0; i < 3; i++) begin
      checks++; if (out_ready !== 1'b0 || out_valid !== 1'b1 || out_pk !== 16'h1111)
        begin failures++; $display("FAIL bp_stall%0d got=ready%0b valid%0b pk%h exp=ready0 valid1 pk1111", i, out_ready, out_valid, out_pk); end
      step();
    end
    ds_ready = 1'b1;
    step();  // X0 emitted, X1 moves out of the skid register
    checks++; if (out_valid !== 1'b1 || out_pk !== 16'h2222)
      begin failures++; $display("FAIL bp_x1 got=valid%0b pk%h exp=valid1 pk2222", out_valid, out_pk); end
    checks++; if (out_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_back got=%0b exp=1", out_ready); end
    step();  // X1 emitted, X2 accepted
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_pk !== 16'h3333)
      begin failures++; $display("FAIL bp_x2 got=valid%0b pk%h exp=valid1 pk3333", out_valid, out_pk); end
    step();  // X2 emitted
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_empty got=%0b exp=0", out_valid); end
    $display("backpressure: X0..X2 drained, valid=%0b ready=%0b", out_valid, out_ready);
  endtask

  task automatic test_stable_hold();
    ds_ready = 1'b0;
    in_valid = 1'b1; a = 16'h1234; b = 16'h00F0; c0 = 1'b1;
    step();
    // The operand is still offered with toggling a. It fills the skid register and then stalls.
    for (int i = 0; i < 10; i++) begin
      a = (i % 2 == 0) ? 16'hFFFF : 16'h0000;
      c0 = 1'b0;
      checks++; if (out_valid !== 1'b1 || out_pk !== 16'h12C4 || out_gk !== 16'h0030 || out_c0 !== 1'b1)
        begin failures++; $display("FAIL hold%0d got=%0b/%h/%h/%0b exp=1/12c4/0030/1", i, out_valid, out_pk, out_gk, out_c0); end
      step();
    end
    $display("stable_hold: pk=%h gk=%h c0=%0b ready=%0b", out_pk, out_gk, out_c0, out_ready);
  endtask

  task automatic test_reset_mid();
    in_valid = 1'b0;
    checks++; if (out_ready !== 1'b0) begin failures++; $display("FAIL rstmid_full got=%0b exp=0", out_ready); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0 || out_pk !== 16'h0 || out_gk !== 16'h0 || out_count !== 16'd0)
      begin failures++; $display("FAIL rstmid_clear got=%0b/%h/%h/%0d exp=0/0000/0000/0", out_valid, out_pk, out_gk, out_count); end
    checks++; if (out_ready !== 1'b1) begin failures++; $display("FAIL rstmid_ready got=%0b exp=1", out_ready); end
    ds_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_ghost%0d got=%0b exp=0", i, out_valid); end
    end
    $display("reset_mid: valid=%0b ready=%0b count=%0d", out_valid, out_ready, out_count);
  endtask

  task automatic test_back_to_back();
    rst = 1'b1;
    step();
    rst = 1'b0;
    ds_ready = 1'b1;
    b = 16'h0; c0 = 1'b0;
    in_valid = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      a = 16'(i * 16'h0101);
      step();
      checks++; if (out_valid !== 1'b1 || out_pk !== 16'(i * 16'h0101))
        begin failures++; $display("FAIL b2b%0d got=valid%0b pk%h exp=valid1 pk%h", i, out_valid, out_pk, 16'(i * 16'h0101)); end
    end
    in_valid = 1'b0;
    checks++; if (out_count !== 16'd17) begin failures++; $display("FAIL count16 got=%0d exp=17", out_count); end
    checks++; if (out_count4 !== 4'd1) begin failures++; $display("FAIL count4_wrap got=%0d exp=1", out_count4); end
    $display("back_to_back: 17 accepts count16=%0d count4=%0d", out_count, out_count4);
    step();
  endtask

`ifdef KS_PG_SUB_EN
  task automatic test_sub();
    ds_ready = 1'b1;
    in_valid = 1'b1; a = 16'h0005; b = 16'h0003; c0 = 1'b0; sub = 1'b1;
    step();
    checks++; if (out_pk !== 16'hFFF9 || out_gk !== 16'h0004 || out_c0 !== 1'b1)
      begin failures++; $display("FAIL sub1 got=%h/%h/%0b exp=fff9/0004/1", out_pk, out_gk, out_c0); end
    sub = 1'b0;
    step();
    in_valid = 1'b0;
    checks++; if (out_pk !== 16'h0006 || out_gk !== 16'h0001 || out_c0 !== 1'b0)
      begin failures++; $display("FAIL sub0 got=%h/%h/%0b exp=0006/0001/0", out_pk, out_gk, out_c0); end
    $display("sub: last pk=%h gk=%h c0=%0b", out_pk, out_gk, out_c0);
    step();
  endtask
`endif

  initial begin
    rst = 1'b0; in_valid = 1'b0; ds_ready = 1'b0;
    a = '0; b = '0; c0 = 1'b0;
`ifdef KS_PG_SUB_EN
    sub = 1'b0;
`endif
    #2;
    test_reset();
    test_basic();
    test_backpressure();
    test_stable_hold();
    test_reset_mid();
    test_back_to_back();
`ifdef KS_PG_SUB_EN
    test_sub();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
